// File: rtl/l2_window_mac_if.sv
// l2_window_mac_if
//   Bundles every non-clock, non-reset signal of l2_window_mac: the
//   weight/bias load port, the start/busy/done control, the layer-1 RAM read
//   port (addr_rd out, din back one cycle later) and the result stream.
//   master : the surrounding system (controller, layer-1 RAM, result sink)
//   slave  : the convolution engine
interface l2_window_mac_if;
  logic               start;
  logic               w_wr;
  logic [3:0]         w_addr;
  logic signed [17:0] w_data;
  logic [7:0]         addr_rd;
  logic signed [17:0] din;
  logic signed [17:0] dout;
  logic               dout_valid;
  logic [6:0]         dout_idx;
  logic               busy;
  logic               done;

  modport master (
    output start, w_wr, w_addr, w_data, din,
    input  addr_rd, dout, dout_valid, dout_idx, busy, done
  );

  modport slave (
    input  start, w_wr, w_addr, w_data, din,
    output addr_rd, dout, dout_valid, dout_idx, busy, done
  );
endinterface

// File: rtl/l2_window_mac.sv
// l2_window_mac
//   Second-layer 3x3 convolution over the 13x13 layer-1 feature map. Walks
//   the 121 windows (r0 outer, c0 inner, taps row-major), issues one RAM read
//   address per cycle, multiply-accumulates the returning data against nine
//   Q1.6 weights plus a bias, then shifts, saturates (and optionally clamps
//   negatives) into an 18-bit result with a one-cycle valid strobe.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset; aborts a pass and clears weights
//   bus    : l2_window_mac_if.slave
//            start, w_wr/w_addr/w_data (ignored while busy),
//            addr_rd -> din (one-cycle read latency),
//            dout/dout_valid/dout_idx, busy, done
//
// Build option
//   L2_RELU_EN : when defined, negative saturated results are replaced by 0.
module l2_window_mac #(
  parameter int SHIFT = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  l2_window_mac_if.slave bus
);

  localparam int DATA_W = 18;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 30;

  localparam logic signed [ACC_W-1:0] SAT_HI = 30'sd131071;
  localparam logic signed [ACC_W-1:0] SAT_LO = -30'sd131072;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic signed [COEF_W-1:0] coef_w [0:8];
  logic signed [DATA_W-1:0] bias;

  logic [3:0] r0, c0, tap;
  logic [6:0] win;
  logic       last_addr;

  logic       vld_p0;
  logic [3:0] tap_p0;
  logic [6:0] idx_p0;

  logic signed [COEF_W-1:0] coef_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc_p1;

  logic signed [DATA_W-1:0] dout_p2;
  logic                     vld_p2;
  logic [6:0]               idx_p2;

  // Offset of tap t from the window's top-left address in a 13-wide map.
  function automatic logic [7:0] tap_off(input logic [3:0] t);
    case (t)
      4'd0:    tap_off = 8'd0;
      4'd1:    tap_off = 8'd1;
      4'd2:    tap_off = 8'd2;
      4'd3:    tap_off = 8'd13;
      4'd4:    tap_off = 8'd14;
      4'd5:    tap_off = 8'd15;
      4'd6:    tap_off = 8'd26;
      4'd7:    tap_off = 8'd27;
      4'd8:    tap_off = 8'd28;
      default: tap_off = 8'd0;
    endcase
  endfunction

  // Arithmetic right shift back to integer scale, then clamp to 18 bits.
  function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> SHIFT;
    if (sh > SAT_HI)
      shift_sat = SAT_HI[DATA_W-1:0];
    else if (sh < SAT_LO)
      shift_sat = SAT_LO[DATA_W-1:0];
    else
      shift_sat = sh[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
`ifdef L2_RELU_EN
    relu = x[DATA_W-1] ? '0 : x;
`else
    relu = x;
`endif
  endfunction

  assign last_addr   = (r0 == 4'd10) && (c0 == 4'd10) && (tap == 4'd8);
  assign bus.addr_rd = 8'(r0) * 8'd13 + 8'(c0) + tap_off(tap);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // DRAIN ends once the last result has been registered (its valid is up).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_addr) state_nxt = DRAIN;
      DRAIN:   if (vld_p2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window/tap walker; wraps to zero after the final address so the next
  // pass starts from window 0 without extra setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0  <= '0;
      c0  <= '0;
      tap <= '0;
      win <= '0;
    end else if (state == RUN) begin
      if (tap == 4'd8) begin
        tap <= '0;
        win <= last_addr ? 7'd0 : win + 7'd1;
        if (c0 == 4'd10) begin
          c0 <= '0;
          r0 <= (r0 == 4'd10) ? 4'd0 : r0 + 4'd1;
        end else begin
          c0 <= c0 + 4'd1;
        end
      end else begin
        tap <= tap + 4'd1;
      end
    end
  end

  // Weights and bias only change between passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) coef_w[k] <= '0;
      bias <= '0;
    end else if (bus.w_wr && (state == IDLE)) begin
      if (bus.w_addr < 4'd9)
        coef_w[bus.w_addr] <= bus.w_data[COEF_W-1:0];
      else if (bus.w_addr == 4'd9)
        bias <= bus.w_data;
    end
  end

  // ---- stage p0: address issued, tap tag follows the RAM read latency ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      tap_p0 <= '0;
      idx_p0 <= '0;
    end else begin
      vld_p0 <= (state == RUN);
      tap_p0 <= tap;
      idx_p0 <= win;
    end
  end

  always_comb begin
    coef_sel = '0;
    if (tap_p0 <= 4'd8) coef_sel = coef_w[tap_p0];
  end

  assign prod     = PROD_W'(bus.din) * PROD_W'(coef_sel);
  // Tap 0 seeds the sum with the bias instead of the previous window's total.
  assign acc_base = (tap_p0 == 4'd0) ? ACC_W'(bias) : acc_p1;
  assign sum      = acc_base + ACC_W'(prod);

  // ---- stage p1: accumulate din * weight ----
  always_ff @(posedge clk) begin
    if (vld_p0) acc_p1 <= sum;
  end

  // ---- stage p2: tap 8 sum scaled, saturated and registered out ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      dout_p2 <= '0;
      idx_p2  <= '0;
    end else begin
      vld_p2 <= vld_p0 && (tap_p0 == 4'd8);
      if (vld_p0 && (tap_p0 == 4'd8)) begin
        dout_p2 <= relu(shift_sat(sum));
        idx_p2  <= idx_p0;
      end
    end
  end

  assign bus.dout       = dout_p2;
  assign bus.dout_valid = vld_p2;
  assign bus.dout_idx   = idx_p2;

endmodule

// File: tb/tb_l2_window_mac.sv
`timescale 1ns/1ps
module tb_l2_window_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_window_mac_if bus();

  l2_window_mac #(.SHIFT(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Layer-1 RAM: registered read, data one cycle after the address.
  logic signed [17:0] ram [0:168];
  always @(posedge clk) bus.din <= (bus.addr_rd <= 8'd168) ? ram[bus.addr_rd] : 18'sd0;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     idx;
    int     val;
    longint cyc;
  } exp_t;

  exp_t   sbq [$];
  int     wm [0:8];
  int     bm;
  int     n_vec = 0;
  int     n_err = 0;
  int     n_valid = 0;
  bit     done_seen = 1'b0;
  longint exp_done = -1;
  int     exp_addr [0:17] = '{0, 1, 2, 13, 14, 15, 26, 27, 28, 1, 2, 3, 14, 15, 16, 27, 28, 29};

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not match expectation", name);
  endtask

  // Reference: direct 3x3 dot product over the stored map, then scale/clamp.
  function automatic int ref_out(input int idx);
    longint s;
    int r, c;
    r = idx / 11;
    c = idx % 11;
    s = bm;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += longint'(ram[(r + i) * 13 + c + j]) * wm[i * 3 + j];
    s = s >>> 6;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
`ifdef L2_RELU_EN
    if (s < 0) s = 0;
`endif
    return int'(s);
  endfunction

  // Monitor: pops the scoreboard on every result strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.dout_valid) begin
        n_valid++;
        if (sbq.size() == 0) begin
          fail("unexpected_valid");
        end else begin
          e = sbq.pop_front();
          check("dout_idx", bus.dout_idx, e.idx);
          check("dout", bus.dout, e.val);
          check("valid_cycle", cyc, e.cyc);
        end
      end
      if (rst_n && bus.done) begin
        check("done_cycle", cyc, exp_done);
        done_seen = 1'b1;
      end
    end
  end

  // All drive tasks are entered and left 1ns after a rising edge.
  task automatic write_w(input int a, input logic [17:0] d);
    bus.w_addr = a[3:0];
    bus.w_data = d;
    bus.w_wr   = 1'b1;
    @(posedge clk); #1;
    bus.w_wr   = 1'b0;
    if (a < 9) wm[a] = int'($signed(d[7:0]));
    else if (a == 9) bm = int'($signed(d));
  endtask

  task automatic load_all(input int tap, input int b);
    for (int k = 0; k < 9; k++) write_w(k, 18'(tap));
    write_w(9, 18'(b));
  endtask

  task automatic load_rand();
    for (int k = 0; k < 9; k++) write_w(k, {10'($urandom), 8'($urandom)});
    write_w(9, 18'($urandom));
  endtask

  task automatic issue_start(output longint s);
    s = cyc;
    n_valid = 0;
    done_seen = 1'b0;
    exp_done = s + 1092;
    for (int i = 0; i < 121; i++) sbq.push_back('{i, ref_out(i), s + 11 + 9 * i});
    bus.start = 1'b1;
    check("busy_idle", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_pass(input bit chk_addr, input bit poke);
    longint s;
    issue_start(s);
    for (int k = 1; k < 1200 && !done_seen; k++) begin
      if (poke && k == 500) begin
        bus.start  = 1'b1;
        bus.w_wr   = 1'b1;
        bus.w_addr = 4'd4;
        bus.w_data = 18'(wm[4] + 77);
      end
      if (poke && k == 501) begin
        bus.start = 1'b0;
        bus.w_wr  = 1'b0;
      end
      @(negedge clk);
      if (k == 1) check("busy_rise", bus.busy, 1);
      if (chk_addr && k <= 18) check("addr_seq", bus.addr_rd, exp_addr[k - 1]);
      if (chk_addr && k == 1089) check("addr_last", bus.addr_rd, 168);
      @(posedge clk); #1;
    end
    if (!done_seen) fail("done_timeout");
    check("valid_count", n_valid, 121);
    check("sb_empty", sbq.size(), 0);
    check("busy_after", bus.busy, 0);
    exp_done = -1;
  endtask

  task automatic check_reset_outputs();
    check("rst_addr_rd", bus.addr_rd, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout_idx", bus.dout_idx, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
  endtask

  task automatic reset_mid_pass();
    longint s;
    issue_start(s);
    for (int k = 0; k < 400 && cyc < s + 300; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sbq.delete();
    exp_done = -1;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    bm = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.w_wr   = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    bm = 0;
    for (int a = 0; a < 169; a++) ram[a] = 18'(a);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Center-tap identity with address sequence and timing
    for (int k = 0; k < 9; k++) write_w(k, (k == 4) ? 18'd64 : 18'd0);
    write_w(9, 18'd0);
    write_w(12, 18'h3ffff);
    run_pass(1'b1, 1'b0);

    // Random weights, moderate map values
    for (int a = 0; a < 169; a++) ram[a] = 18'(int'($urandom_range(0, 4000)) - 2000);
    load_rand();
    run_pass(1'b0, 1'b0);

    // Random weights, full-range map
    for (int a = 0; a < 169; a++) ram[a] = 18'($urandom);
    load_rand();
    run_pass(1'b0, 1'b0);

    // Saturation both ways
    for (int a = 0; a < 169; a++) ram[a] = 18'sd131071;
    load_all(127, 0);
    run_pass(1'b0, 1'b0);
    load_all(-128, 0);
    run_pass(1'b0, 1'b0);

    // Bias only, negative and positive
    load_all(0, -640);
    run_pass(1'b0, 1'b0);
    load_all(0, 640);
    run_pass(1'b0, 1'b0);

    // Start and weight write while busy are ignored, also for the next pass
    for (int a = 0; a < 169; a++) ram[a] = 18'(int'($urandom_range(0, 20000)) - 10000);
    load_rand();
    run_pass(1'b0, 1'b1);
    run_pass(1'b0, 1'b0);

    // Mid-pass reset, then a clean pass with cleared weights
    load_rand();
    reset_mid_pass();
    run_pass(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_window_mac.md
# l2_window_mac

Second-layer 3x3 convolution engine that reads the 13x13 layer-1 feature map stored in the layer-1 RAM. It generates the read addresses, consumes the RAM's registered read data, and multiply-accumulates each 3x3 window against nine loaded weights plus a bias. It emits the 11x11 = 121 scaled, saturated results with a valid strobe. The block sits directly downstream of the layer-1 RAM read port.

## Interface
- SHIFT, 6, arithmetic right shift applied to the accumulator before saturation; weights are Q1.6, so 64 = 1.0.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a full map pass; ignored while busy.
- w_wr  in  1  weight/bias write strobe; ignored while busy.
- w_addr  in  4  write index: 0-8 = weight tap (row-major), 9 = bias, 10-15 ignored.
- w_data  in  18  write data: signed; taps use bits [7:0], bias uses all 18 bits.
- addr_rd  out  8  layer-1 RAM read address, range 0..168.
- din  in  18  signed layer-1 RAM read data, valid one cycle after addr_rd.
- dout  out  18  signed convolution result.
- dout_valid  out  1  one-cycle strobe qualifying dout and dout_idx.
- dout_idx  out  7  output index 0..120, computed as r0*11+c0.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse after the final result.

## Operation
- Reset values: addr_rd=0, dout=0, dout_valid=0, dout_idx=0, busy=0, done=0. All weights and the bias reset to 0. The FSM resets to IDLE.
- FSM states and transitions:
  - IDLE --start--> RUN.
  - RUN: issues one address per cycle. After the last address it goes to DRAIN.
  - DRAIN: waits out the pipeline until the final result is registered, then goes to DONE.
  - DONE: pulses done for one cycle, then returns to IDLE.
- Window order: r0 runs 0..10 in the outer loop and c0 runs 0..10 in the inner loop. Taps within a window are row-major, (i,j) with i,j in 0..2.
- Tap address: addr_rd = (r0+i)*13 + (c0+j). Window 0, tap 0 reads address 0; window 120, tap 8 reads address 168.
- Windows are issued back to back with no gap cycle between them.
- Product: din (18b signed) * weight (8b signed) gives a 26b product.
- Accumulator: 30b signed.
  - Tap 0: acc <= sign-extended bias + product.
  - Taps 1-7: acc <= acc + product.
  - Tap 8: the final sum acc + product feeds the output stage directly.
- Output stage: the final sum is arithmetically shifted right by SHIFT, then saturated to [-131072, 131071], then passed through the optional ReLU, then registered into dout.
- w_wr updates the register selected by w_addr at the clock edge, only when busy=0.
- A start that arrives during RUN, DRAIN or DONE is ignored.
- An rst_n assertion mid-pass aborts the pass immediately. No dout_valid or done is produced afterwards, and the loaded weights are cleared.

## Timing
- Tap k of a window is issued on addr_rd in cycle c+k, where c is the cycle tap 0 is issued.
- Its din arrives in cycle c+k+1 and is accumulated at the end of that cycle.
- dout_valid is high in cycle c+10, giving a latency of 10 cycles from tap 0.
- Throughput is one result per 9 cycles.
- The first addr_rd is issued in the cycle after start; busy rises in that same cycle.
- The last dout_valid occurs 1 + 121*9 + 1 = 1091 cycles after start.
- done pulses in the following cycle, and busy falls together with done.

## Configuration
- L2_RELU_EN defined: negative saturated results are replaced with 0 before registering.
- L2_RELU_EN undefined: signed saturated results pass through unchanged.

## Test plan
- Center-tap identity:
  - Stimulus: w[4]=64, other weights 0, bias 0, RAM[a]=a.
  - Required: dout_idx 0 → 14, idx 1 → 15, idx 11 → 27, idx 120 → 154; exactly 121 valid strobes, spaced 9 cycles apart.
- Address sequence:
  - Required: the first 18 addresses after start are 0,1,2,13,14,15,26,27,28,1,2,3,14,15,16,27,28,29; the final address is 168; done arrives 1092 cycles after start.
- Saturation:
  - Stimulus: all weights 127, RAM all 131071.
  - Required: every dout = 131071.
  - Stimulus: weights -128, same RAM.
  - Required: every dout = -131072, or 0 with L2_RELU_EN defined.
- Bias and ReLU:
  - Stimulus: weights 0, bias = -640.
  - Required: dout = -10 without the macro, 0 with it. With bias = 640: dout = 10 in both builds.
- Mid-pass reset:
  - Stimulus: assert rst_n low at cycle 300 of a pass.
  - Required: outputs return to reset values at once, weights read back as 0, and a new start runs a clean pass.
- Start/write during busy:
  - Stimulus: a second start and a w_wr to w_addr 4 mid-pass.
  - Required: both are ignored; the results and the 1091-cycle timing are unchanged.
